// File: rtl/fir_axis_bist.sv
// AXI-Stream stimulus/response engine for the FIR datapath: drives ss_*, checks sm_* against golden memory.
// Latency: first ss word valid the cycle after start; done/pass the cycle after the last sink beat or watchdog expiry.
// Backpressure: ss words held stable until ss_tready; sm_tready optionally LFSR-gated. FIR_BIST_LATENCY_EN builds lat_first/run_cycles.
module fir_axis_bist #(
    parameter int          pDATA_WIDTH = 32,
    parameter int          pDEPTH_LOG2 = 10,
    parameter logic [15:0] pLFSR_SEED  = 16'hACE1
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   vec_we,
    input  logic                   vec_sel,
    input  logic [pDEPTH_LOG2-1:0] vec_addr,
    input  logic [pDATA_WIDTH-1:0] vec_wdata,
    input  logic                   start,
    input  logic [pDEPTH_LOG2:0]   length,
    input  logic                   src_throttle,
    input  logic                   snk_throttle,
    input  logic [19:0]            timeout_cycles,
    output logic                   ss_tvalid,
    output logic [pDATA_WIDTH-1:0] ss_tdata,
    output logic                   ss_tlast,
    input  logic                   ss_tready,
    input  logic                   sm_tvalid,
    input  logic [pDATA_WIDTH-1:0] sm_tdata,
    input  logic                   sm_tlast,
    output logic                   sm_tready,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [15:0]            err_count,
    output logic [pDEPTH_LOG2-1:0] first_err_idx,
    output logic [pDATA_WIDTH-1:0] first_err_data,
    output logic                   tlast_err,
    output logic                   timeout,
    output logic [19:0]            lat_first,
    output logic [19:0]            run_cycles
);

    localparam int                   DEPTH   = 1 << pDEPTH_LOG2;
    localparam logic [pDEPTH_LOG2:0] IDX_ONE = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    logic [pDATA_WIDTH-1:0] stim_mem [DEPTH];
    logic [pDATA_WIDTH-1:0] gold_mem [DEPTH];

    state_t                 state;
    logic [pDEPTH_LOG2:0]   len_m1;
    logic [pDEPTH_LOG2:0]   src_idx;
    logic [pDEPTH_LOG2:0]   snk_idx;
    logic [15:0]            lfsr;
    logic [19:0]            wd_cnt;

    logic                   start_ok;
    logic                   src_offer;
    logic                   src_more;
    logic                   snk_fire;
    logic                   snk_last;
    logic                   snk_mismatch;
    logic                   wd_expired;
    logic [pDATA_WIDTH-1:0] src_word;

    // Vector memories have no reset and accept writes in every state.
    always_ff @(posedge axis_clk) begin
        if (vec_we) begin
            if (vec_sel)
                gold_mem[vec_addr] <= vec_wdata;
            else
                stim_mem[vec_addr] <= vec_wdata;
        end
    end

    assign start_ok     = start && (length != '0) && (state != RUN);
    assign src_offer    = !src_throttle || lfsr[0];
    assign src_more     = (src_idx <= len_m1);
    assign src_word     = stim_mem[src_idx[pDEPTH_LOG2-1:0]];
    assign snk_fire     = sm_tvalid && sm_tready;
    assign snk_last     = (snk_idx == len_m1);
    assign snk_mismatch = (sm_tdata != gold_mem[snk_idx[pDEPTH_LOG2-1:0]]);
    assign wd_expired   = (timeout_cycles != '0) && (wd_cnt == timeout_cycles);

    assign sm_tready = (state == RUN) && (!snk_throttle || lfsr[7]);
    assign pass      = done && (err_count == '0) && !tlast_err && !timeout;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state          <= IDLE;
            len_m1         <= '0;
            src_idx        <= '0;
            snk_idx        <= '0;
            lfsr           <= pLFSR_SEED;
            wd_cnt         <= '0;
            ss_tvalid      <= 1'b0;
            ss_tdata       <= '0;
            ss_tlast       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
            tlast_err      <= 1'b0;
            timeout        <= 1'b0;
        end else begin
            if (state == RUN)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        len_m1         <= length - IDX_ONE;
                        snk_idx        <= '0;
                        wd_cnt         <= '0;
                        err_count      <= '0;
                        first_err_idx  <= '0;
                        first_err_data <= '0;
                        tlast_err      <= 1'b0;
                        timeout        <= 1'b0;
                        // First word is preloaded so ss_tvalid can rise together with busy.
                        if (src_offer) begin
                            ss_tvalid <= 1'b1;
                            ss_tdata  <= stim_mem[0];
                            ss_tlast  <= (length == IDX_ONE);
                            src_idx   <= IDX_ONE;
                        end else begin
                            ss_tvalid <= 1'b0;
                            src_idx   <= '0;
                        end
                    end
                end
                RUN: begin
                    if (!ss_tvalid || ss_tready) begin
                        if (src_more && src_offer) begin
                            ss_tvalid <= 1'b1;
                            ss_tdata  <= src_word;
                            ss_tlast  <= (src_idx == len_m1);
                            src_idx   <= src_idx + IDX_ONE;
                        end else begin
                            ss_tvalid <= 1'b0;
                        end
                    end

                    if (snk_fire) begin
                        wd_cnt  <= '0;
                        snk_idx <= snk_idx + IDX_ONE;
                        if (snk_mismatch) begin
                            if (err_count != '1)
                                err_count <= err_count + 16'd1;
                            if (err_count == '0) begin
                                first_err_idx  <= snk_idx[pDEPTH_LOG2-1:0];
                                first_err_data <= sm_tdata;
                            end
                        end
                        if (sm_tlast != snk_last)
                            tlast_err <= 1'b1;
                        if (snk_last) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            ss_tvalid <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        // Abort: the source is withdrawn even mid-transfer.
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                        ss_tvalid <= 1'b0;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 20'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_BIST_LATENCY_EN
    logic ss_seen;
    logic sm_seen;
    logic ss_fire;

    assign ss_fire = ss_tvalid && ss_tready;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ss_seen    <= 1'b0;
            sm_seen    <= 1'b0;
            lat_first  <= '0;
            run_cycles <= '0;
        end else if (start_ok) begin
            ss_seen    <= 1'b0;
            sm_seen    <= 1'b0;
            lat_first  <= '0;
            run_cycles <= '0;
        end else if (state == RUN) begin
            if (run_cycles != '1)
                run_cycles <= run_cycles + 20'd1;
            if (ss_fire)
                ss_seen <= 1'b1;
            if (snk_fire)
                sm_seen <= 1'b1;
            // Counts cycles from the first source handshake up to, not including, the first sink handshake.
            if ((ss_seen || ss_fire) && !sm_seen && !snk_fire && (lat_first != '1))
                lat_first <= lat_first + 20'd1;
        end
    end
`else
    assign lat_first  = '0;
    assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_fir_axis_bist.sv
// Scoreboard bench for fir_axis_bist: ss looped back to sm through a one-stage register.
module tb_fir_axis_bist;
    localparam int DW = 32;
    localparam int AW = 10;

    logic          axis_clk = 1'b0;
    logic          axis_rst_n;
    logic          vec_we, vec_sel, start, src_throttle, snk_throttle;
    logic [AW-1:0] vec_addr;
    logic [DW-1:0] vec_wdata;
    logic [AW:0]   length;
    logic [19:0]   timeout_cycles;
    logic          ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0] ss_tdata;
    logic          sm_tvalid, sm_tlast, sm_tready;
    logic [DW-1:0] sm_tdata;
    logic          busy, done, pass, tlast_err, timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_idx;
    logic [DW-1:0] first_err_data;
    logic [19:0]   lat_first, run_cycles;

    always #5 axis_clk = ~axis_clk;

    fir_axis_bist dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .vec_we(vec_we), .vec_sel(vec_sel), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .start(start), .length(length), .src_throttle(src_throttle), .snk_throttle(snk_throttle),
        .timeout_cycles(timeout_cycles),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data),
        .tlast_err(tlast_err), .timeout(timeout), .lat_first(lat_first), .run_cycles(run_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // One-stage loopback register standing in for the FIR core.
    logic          lb_vld, lb_last, force_rdy0, force_last0;
    logic [DW-1:0] lb_dat;
    always @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            lb_vld  <= 1'b0;
            lb_dat  <= '0;
            lb_last <= 1'b0;
        end else if (!lb_vld || sm_tready) begin
            lb_vld  <= ss_tvalid && ss_tready;
            lb_dat  <= ss_tdata;
            lb_last <= ss_tlast;
        end
    end
    assign ss_tready = !force_rdy0 && (!lb_vld || sm_tready);
    assign sm_tvalid = lb_vld;
    assign sm_tdata  = lb_dat;
    assign sm_tlast  = lb_last && !force_last0;

    typedef struct {
        string         nm;
        logic [15:0]   errs;
        logic [AW-1:0] fidx;
        logic [DW-1:0] fdat;
        logic          tl;
        logic          to;
        logic          ps;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          cur;
    logic [DW-1:0] stim_model [1024];
    int            ss_cnt  = 0;
    int            cur_len = 0;
    logic          done_d  = 1'b0;
    logic          stab_en = 1'b0;
    logic          hold_pend = 1'b0;
    logic [DW-1:0] hold_dat;

    function automatic exp_t mk(string nm, int errs, int fidx, int fdat, bit tl, bit to, bit ps);
        exp_t e;
        e.nm = nm; e.errs = 16'(errs); e.fidx = AW'(fidx); e.fdat = DW'(fdat);
        e.tl = tl; e.to = to; e.ps = ps;
        return e;
    endfunction

    // Monitor: status on done rising, source words on each ss handshake, AXIS hold-stability.
    always @(negedge axis_clk) begin
        if (!axis_rst_n) begin
            done_d    = 1'b0;
            ss_cnt    = 0;
            hold_pend = 1'b0;
        end else begin
            if (done && !done_d) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    cur = sb_q.pop_front();
                    chk({cur.nm, "_err_count"}, err_count, cur.errs);
                    chk({cur.nm, "_first_idx"}, first_err_idx, cur.fidx);
                    chk({cur.nm, "_first_data"}, first_err_data, cur.fdat);
                    chk({cur.nm, "_tlast_err"}, tlast_err, cur.tl);
                    chk({cur.nm, "_timeout"}, timeout, cur.to);
                    chk({cur.nm, "_pass"}, pass, cur.ps);
                    chk({cur.nm, "_busy"}, busy, 0);
                end
            end
            done_d = done;
            if (stab_en && hold_pend) begin
                chk("stable_vld", ss_tvalid, 1);
                chk("stable_dat", ss_tdata, hold_dat);
            end
            hold_pend = ss_tvalid && !ss_tready;
            hold_dat  = ss_tdata;
            if (ss_tvalid && ss_tready) begin
                if (ss_cnt < 1024) begin
                    chk("ss_data", ss_tdata, stim_model[ss_cnt]);
                    chk("ss_last", ss_tlast, (ss_cnt == cur_len - 1));
                end else begin
                    chk("ss_overrun", ss_cnt, 1023);
                end
                ss_cnt++;
            end
        end
    end

    task automatic wr(input logic sel, input int addr, input logic [DW-1:0] data);
        vec_we = 1'b1; vec_sel = sel; vec_addr = AW'(addr); vec_wdata = data;
        @(posedge axis_clk); #1;
        vec_we = 1'b0;
    endtask

    task automatic run(input int len, input exp_t e, input int budget, output int cyc);
        sb_q.push_back(e);
        cur_len = len;
        ss_cnt  = 0;
        @(posedge axis_clk); #1;
        length = (AW+1)'(len);
        start  = 1'b1;
        @(posedge axis_clk); #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(negedge axis_clk);
            cyc++;
        end while (!done && cyc < budget);
        if (!done)
            chk({e.nm, "_done_wait"}, 0, 1);
        @(posedge axis_clk); #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, pass, 0);
        chk({tag, "_ss_tvalid"}, ss_tvalid, 0);
        chk({tag, "_ss_tlast"}, ss_tlast, 0);
        chk({tag, "_ss_tdata"}, ss_tdata, 0);
        chk({tag, "_sm_tready"}, sm_tready, 0);
        chk({tag, "_err_count"}, err_count, 0);
        chk({tag, "_first_idx"}, first_err_idx, 0);
        chk({tag, "_first_data"}, first_err_data, 0);
        chk({tag, "_tlast_err"}, tlast_err, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_lat_first"}, lat_first, 0);
        chk({tag, "_run_cycles"}, run_cycles, 0);
    endtask

    initial begin
        int cyc;
        axis_rst_n = 1'b0;
        vec_we = 1'b0; vec_sel = 1'b0; vec_addr = '0; vec_wdata = '0;
        start = 1'b0; length = '0; src_throttle = 1'b0; snk_throttle = 1'b0;
        timeout_cycles = '0; force_rdy0 = 1'b0; force_last0 = 1'b0;
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check_reset("reset");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;

        for (int i = 0; i < 1024; i++) begin
            stim_model[i] = DW'(i);
            wr(1'b0, i, DW'(i));
            wr(1'b1, i, DW'(i));
        end

        // Plain loopback, 16 words.
        run(16, mk("loop16", 0, 0, 0, 0, 0, 1), 200, cyc);
`ifdef FIR_BIST_LATENCY_EN
        chk("loop16_run_cycles", run_cycles, 17);
        chk("loop16_lat_first", lat_first, 1);
`else
        chk("loop16_run_cycles_off", run_cycles, 0);
        chk("loop16_lat_first_off", lat_first, 0);
`endif

        // start with length 0 is ignored; done holds.
        length = '0;
        start  = 1'b1;
        @(posedge axis_clk); #1;
        start = 1'b0;
        @(negedge axis_clk);
        chk("len0_busy", busy, 0);
        chk("len0_done_hold", done, 1);
        chk("len0_pass_hold", pass, 1);

        // Two corrupted golden words.
        wr(1'b1, 5, 32'd100);
        wr(1'b1, 9, 32'd200);
        run(16, mk("corrupt", 2, 5, 5, 0, 0, 0), 200, cyc);
        wr(1'b1, 5, 32'd5);
        wr(1'b1, 9, 32'd9);

        // Single-word run: first word is also the last.
        run(1, mk("len1", 0, 0, 0, 0, 0, 1), 50, cyc);

        // Full depth with both throttles and hold-stability checking.
        src_throttle = 1'b1; snk_throttle = 1'b1; timeout_cycles = 20'd500; stab_en = 1'b1;
        run(1024, mk("thr1024", 0, 0, 0, 0, 0, 1), 20000, cyc);
        src_throttle = 1'b0; snk_throttle = 1'b0; timeout_cycles = '0; stab_en = 1'b0;

        // sm_tlast forced low.
        force_last0 = 1'b1;
        run(4, mk("tlast", 0, 0, 0, 1, 0, 0), 50, cyc);
        force_last0 = 1'b0;

        // Watchdog with the FIR input stuck not-ready.
        force_rdy0 = 1'b1; timeout_cycles = 20'd100;
        run(16, mk("timeout", 0, 0, 0, 0, 1, 0), 300, cyc);
        chk("timeout_latency", (cyc >= 100 && cyc <= 103), 1);
        chk("timeout_ss_tvalid", ss_tvalid, 0);
        chk("timeout_sm_tready", sm_tready, 0);
        force_rdy0 = 1'b0; timeout_cycles = '0;

        // Reset at beat 7 of a 16-word run, then a clean rerun.
        cur_len = 16;
        ss_cnt  = 0;
        length  = 11'd16;
        start   = 1'b1;
        @(posedge axis_clk); #1;
        start = 1'b0;
        cyc = 0;
        while (ss_cnt < 7 && cyc < 100) begin
            @(negedge axis_clk);
            cyc++;
        end
        chk("midrst_reached_beat7", (ss_cnt >= 7), 1);
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b0;
        @(negedge axis_clk);
        check_reset("midrst");
        @(posedge axis_clk); #1;
        axis_rst_n = 1'b1;
        run(16, mk("after_rst", 0, 0, 0, 0, 0, 1), 200, cyc);

        repeat (3) @(negedge axis_clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
